// File: rtl/fix_pkg.sv
// fix_pkg: constants, error codes and state encoding shared by the FIX receive path.
package fix_pkg;

  localparam logic [7:0] SOH      = 8'h01;
  localparam logic [7:0] ASCII_EQ = 8'h3D;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;

  // Tags are right-aligned ASCII, first character most significant.
  localparam logic [31:0] T_BEGINSTRING = 32'h0000_0038;
  localparam logic [31:0] T_BODYLENGTH  = 32'h0000_0039;
  localparam logic [31:0] T_CHECKSUM    = 32'h0000_3130;

  typedef enum logic [2:0] {
    E_NONE         = 3'd0,
    E_BAD_TAG_CHAR = 3'd1,
    E_TAG_OVF      = 3'd2,
    E_VAL_OVF      = 3'd3,
    E_EMPTY        = 3'd4,
    E_CHECKSUM     = 3'd5,
    E_BODYLEN      = 3'd6,
    E_CHK_FMT      = 3'd7
  } err_code_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_TAG   = 3'd1,
    S_VAL   = 3'd2,
    S_EMIT  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

endpackage

// File: rtl/fix_ascii_to_bin.sv
// fix_ascii_to_bin: serial ASCII decimal accumulator; flags any non-digit seen since the last clear.
module fix_ascii_to_bin
  import fix_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        digit_valid,
  input  logic [7:0]  digit,
  output logic [16:0] value,
  output logic        nondigit
);

  logic [7:0] digit_bin;

  always_comb digit_bin = digit - ASCII_0;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      value    <= 17'd0;
      nondigit <= 1'b0;
    end else if (digit_valid) begin
      if (is_digit(digit)) begin
        value <= value * 17'd10 + {9'd0, digit_bin};
      end else begin
        nondigit <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fix_field_parser.sv
// fix_field_parser: splits a FIX byte stream into tag/value fields and verifies the CheckSum trailer.
// Define FIX_BODYLEN_CHECK_EN to also verify BodyLength (tag 9) against the counted body bytes.
module fix_field_parser
  import fix_pkg::*;
#(
  parameter int VALUE_WIDTH = 256,
  parameter int SIZE        = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rx_data_i,
  input  logic                   rx_valid_i,
  output logic                   rx_ready_o,
  output logic [31:0]            tag_o,
  output logic [4:0]             t_size_o,
  output logic [VALUE_WIDTH-1:0] val_o,
  output logic [SIZE-1:0]        v_size_o,
  output logic                   field_valid_o,
  input  logic                   field_ready_i,
  output logic                   last_o,
  output logic                   chk_ok_o,
  output logic                   err_valid_o,
  output logic [2:0]             err_code_o
);

  localparam int MAX_VLEN = VALUE_WIDTH / 8;

  state_t     state;
  logic       at_field_start;
  logic [7:0] sum;
  logic [7:0] sum_commit;

  logic       accept, is_soh, is_eq, msg_start, val_start, val_digit, tag_is_10;
  logic       last_fmt_ok, last_sum_ok, bodylen_bad;
  err_code_t  byte_err, last_err;
  logic [16:0] chk_value;
  logic        chk_nondigit;

  always_comb begin
    accept    = rx_valid_i && rx_ready_o;
    is_soh    = (rx_data_i == SOH);
    is_eq     = (rx_data_i == ASCII_EQ);
    msg_start = accept && (state == S_IDLE) && at_field_start && (rx_data_i == T_BEGINSTRING[7:0]);
    val_start = accept && (state == S_TAG) && is_eq;
    val_digit = accept && (state == S_VAL) && !is_soh;
    tag_is_10 = (t_size_o == 5'd2) && (tag_o == T_CHECKSUM);
  end

  // Per-byte framing errors; these abandon the field and drain to the next SOH.
  always_comb begin
    byte_err = E_NONE;
    if (accept && (state == S_TAG)) begin
      if (is_digit(rx_data_i)) begin
        byte_err = (t_size_o == 5'd4) ? E_TAG_OVF : E_NONE;
      end else if (is_eq) begin
        byte_err = (t_size_o == 5'd0) ? E_EMPTY : E_NONE;
      end else begin
        byte_err = E_BAD_TAG_CHAR;
      end
    end else if (accept && (state == S_VAL)) begin
      if (is_soh) begin
        byte_err = (v_size_o == {SIZE{1'b0}}) ? E_EMPTY : E_NONE;
      end else begin
        byte_err = (v_size_o == SIZE'(MAX_VLEN)) ? E_VAL_OVF : E_NONE;
      end
    end else begin
      byte_err = E_NONE;
    end
  end

  fix_ascii_to_bin u_chk_dec (
    .clk(clk), .rst(rst), .clear(val_start), .digit_valid(val_digit),
    .digit(rx_data_i), .value(chk_value), .nondigit(chk_nondigit)
  );

  // Trailer verdict, evaluated while the CheckSum field's SOH is accepted; sum_commit still covers the preceding SOH.
  always_comb begin
    last_fmt_ok = (v_size_o == SIZE'(3)) && !chk_nondigit;
    last_sum_ok = ((chk_value & 17'h000FF) == {9'd0, sum_commit});
    if (!last_fmt_ok) begin
      last_err = E_CHK_FMT;
    end else if (!last_sum_ok) begin
      last_err = E_CHECKSUM;
    end else if (bodylen_bad) begin
      last_err = E_BODYLEN;
    end else begin
      last_err = E_NONE;
    end
  end

`ifdef FIX_BODYLEN_CHECK_EN
  logic        tag_is_9, bl_active, bl_fmt_ok, bl_nondigit;
  logic [16:0] bl_dec_value, bl_value, bl_count, bl_commit;

  fix_ascii_to_bin u_bodylen_dec (
    .clk(clk), .rst(rst), .clear(val_start), .digit_valid(val_digit),
    .digit(rx_data_i), .value(bl_dec_value), .nondigit(bl_nondigit)
  );

  always_comb tag_is_9 = (t_size_o == 5'd1) && (tag_o == T_BODYLENGTH);

  // bl_commit counts from the byte after tag 9's SOH through the most recent SOH.
  always_ff @(posedge clk) begin
    if (rst || msg_start) begin
      bl_active <= 1'b0;
      bl_fmt_ok <= 1'b0;
      bl_value  <= 17'd0;
      bl_count  <= 17'd0;
      bl_commit <= 17'd0;
    end else if (accept && (state == S_VAL) && is_soh && tag_is_9) begin
      bl_active <= 1'b1;
      bl_fmt_ok <= (v_size_o <= SIZE'(5)) && !bl_nondigit;
      bl_value  <= bl_dec_value;
      bl_count  <= 17'd0;
    end else if (accept && bl_active) begin
      bl_count <= bl_count + 17'd1;
      if (is_soh) begin
        bl_commit <= bl_count + 17'd1;
      end
    end
  end

  always_comb bodylen_bad = bl_active && (!bl_fmt_ok || (bl_value != bl_commit));
`else
  always_comb bodylen_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      at_field_start <= 1'b1;
      sum            <= 8'd0;
      sum_commit     <= 8'd0;
      rx_ready_o     <= 1'b1;
      tag_o          <= 32'd0;
      t_size_o       <= 5'd0;
      val_o          <= {VALUE_WIDTH{1'b0}};
      v_size_o       <= {SIZE{1'b0}};
      field_valid_o  <= 1'b0;
      last_o         <= 1'b0;
      chk_ok_o       <= 1'b0;
      err_valid_o    <= 1'b0;
      err_code_o     <= 3'd0;
    end else begin
      err_valid_o <= 1'b0;
      if (accept) begin
        at_field_start <= is_soh;
        sum            <= sum + rx_data_i;
      end
      if (byte_err != E_NONE) begin
        err_valid_o <= 1'b1;
        err_code_o  <= byte_err;
        state       <= is_soh ? S_IDLE : S_DRAIN;
      end else begin
        case (state)
          S_IDLE: begin
            if (msg_start) begin
              state    <= S_TAG;
              sum      <= rx_data_i;
              tag_o    <= {24'd0, rx_data_i};
              t_size_o <= 5'd1;
            end
          end
          S_TAG: begin
            if (accept) begin
              if (is_eq) begin
                state    <= S_VAL;
                val_o    <= {VALUE_WIDTH{1'b0}};
                v_size_o <= {SIZE{1'b0}};
              end else begin
                tag_o    <= {tag_o[23:0], rx_data_i};
                t_size_o <= t_size_o + 5'd1;
              end
            end
          end
          S_VAL: begin
            if (accept) begin
              if (is_soh) begin
                state         <= S_EMIT;
                rx_ready_o    <= 1'b0;
                field_valid_o <= 1'b1;
                last_o        <= tag_is_10;
                sum_commit    <= sum + rx_data_i;
                if (tag_is_10) begin
                  chk_ok_o    <= last_fmt_ok && last_sum_ok;
                  err_valid_o <= (last_err != E_NONE);
                  err_code_o  <= last_err;
                end
              end else begin
                val_o    <= {val_o[VALUE_WIDTH-9:0], rx_data_i};
                v_size_o <= v_size_o + SIZE'(1);
              end
            end
          end
          S_EMIT: begin
            if (field_ready_i) begin
              state         <= last_o ? S_IDLE : S_TAG;
              rx_ready_o    <= 1'b1;
              field_valid_o <= 1'b0;
              last_o        <= 1'b0;
              chk_ok_o      <= 1'b0;
              tag_o         <= 32'd0;
              t_size_o      <= 5'd0;
            end
          end
          S_DRAIN: begin
            if (accept && is_soh) begin
              state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fix_field_parser.sv
// tb_fix_field_parser: table of whole FIX messages with expected field/error outcomes, plus stall and reset sequences.
module tb_fix_field_parser;

  localparam int VW = 256;
  localparam int SZ = 64;
`ifdef FIX_BODYLEN_CHECK_EN
  localparam int BL_ERR = 6;
`else
  localparam int BL_ERR = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [31:0]   tag;
  logic [4:0]    t_size;
  logic [VW-1:0] val;
  logic [SZ-1:0] v_size;
  logic          field_valid;
  logic          field_ready;
  logic          last;
  logic          chk_ok;
  logic          err_valid;
  logic [2:0]    err_code;

  fix_field_parser #(.VALUE_WIDTH(VW), .SIZE(SZ)) dut (
    .clk(clk), .rst(rst),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
    .tag_o(tag), .t_size_o(t_size), .val_o(val), .v_size_o(v_size),
    .field_valid_o(field_valid), .field_ready_i(field_ready),
    .last_o(last), .chk_ok_o(chk_ok),
    .err_valid_o(err_valid), .err_code_o(err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] tag;
    logic [4:0]  tsize;
    logic [63:0] val;
    logic        val_hi_zero;
    logic [63:0] vsize;
    logic        last;
    logic        chk;
  } field_t;

  typedef struct {
    string msg;
    int    nf;
    int    nl;
    int    chk;
    int    err;
    int    f1vs;
  } vec_t;

  field_t     fq[$];
  logic [2:0] eq[$];
  int         consumed = 0;
  int         nvec = 0;
  int         nmis = 0;

  // Observe handshakes on the falling edge, where all DUT outputs and bench inputs are settled.
  always @(negedge clk) begin
    if (rx_valid && rx_ready) consumed <= consumed + 1;
    if (field_valid && field_ready)
      fq.push_back('{tag, t_size, val[63:0], ~|val[VW-1:64], v_size, last, chk_ok});
    if (err_valid) eq.push_back(err_code);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the byte was accepted.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      nvec++;
      nmis++;
      $display("FAIL byte_timeout: got ready=0 for %0d cycles want ready=1", n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_msg(input string s);
    for (int j = 0; j < s.len(); j++)
      send_byte((s.getc(j) == 8'h7C) ? 8'h01 : s.getc(j));
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_rx_ready"}, {63'd0, rx_ready}, 64'd1);
    check({pfx, "_field_valid"}, {63'd0, field_valid}, 64'd0);
    check({pfx, "_tag"}, {32'd0, tag}, 64'd0);
    check({pfx, "_t_size"}, {59'd0, t_size}, 64'd0);
    check({pfx, "_val_zero"}, {63'd0, |val}, 64'd0);
    check({pfx, "_v_size"}, v_size, 64'd0);
    check({pfx, "_last_chk_err"}, {61'd0, last, chk_ok, err_valid}, 64'd0);
    check({pfx, "_err_code"}, {61'd0, err_code}, 64'd0);
  endtask

  vec_t  vecs[12];
  string good, a33, b32;

  logic [31:0] etag[4]  = '{32'h38, 32'h39, 32'h3335, 32'h3130};
  logic [4:0]  etsz[4]  = '{5'd1, 5'd1, 5'd2, 5'd2};
  logic [63:0] eval[4]  = '{64'h0046_4958_2E34_2E32, 64'h35, 64'h30, 64'h31_3631};
  logic [63:0] evsz[4]  = '{64'd7, 64'd1, 64'd1, 64'd3};

  initial begin
    int nlast;
    int w;
    int snap;

    good = "8=FIX.4.2|9=5|35=0|10=161|";
    a33 = "";
    b32 = "";
    for (int j = 0; j < 33; j++) a33 = {a33, "A"};
    for (int j = 0; j < 32; j++) b32 = {b32, "B"};

    //          message                                    nf nl chk err     f1vs
    vecs[0]  = '{good,                                      4, 1, 1, 0,      1};
    vecs[1]  = '{"8=FIX.4.2|9=5|35=0|10=162|",              4, 1, 0, 5,      1};
    vecs[2]  = '{{"8=FIX.4.2|58=", a33, "|10=000|"},        1, 0, 0, 3,     -1};
    vecs[3]  = '{good,                                      4, 1, 1, 0,      1};
    vecs[4]  = '{"8=FIX.4.2|9=6|35=0|10=162|",              4, 1, 1, BL_ERR, 1};
    vecs[5]  = '{"8=FIX.4.2|3A=0|",                         1, 0, 0, 1,     -1};
    vecs[6]  = '{"8=FIX.4.2|12345=0|",                      1, 0, 0, 2,     -1};
    vecs[7]  = '{"8=FIX.4.2|=0|",                           1, 0, 0, 4,     -1};
    vecs[8]  = '{"8=FIX.4.2|35=|",                          1, 0, 0, 4,     -1};
    vecs[9]  = '{"8=FIX.4.2|9=5|35=0|10=16|",               4, 1, 0, 7,      1};
    vecs[10] = '{"zz|8=FIX.4.2|9=5|35=0|10=161|",           4, 1, 1, 0,      1};
    vecs[11] = '{{"8=FIX.4.2|58=", b32, "|10=010|"},        3, 1, 1, 0,     32};

    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    field_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      fq.delete();
      eq.delete();
      send_msg(vecs[i].msg);
      idle(8);
      nlast = 0;
      foreach (fq[k]) if (fq[k].last) nlast++;
      check($sformatf("v%0d_nfields", i), 64'(fq.size()), 64'(vecs[i].nf));
      check($sformatf("v%0d_nlast", i), 64'(nlast), 64'(vecs[i].nl));
      if (vecs[i].nl > 0 && fq.size() > 0)
        check($sformatf("v%0d_chk_ok", i), {63'd0, fq[fq.size()-1].chk}, 64'(vecs[i].chk));
      check($sformatf("v%0d_nerr", i), 64'(eq.size()), (vecs[i].err != 0) ? 64'd1 : 64'd0);
      if (vecs[i].err != 0 && eq.size() > 0)
        check($sformatf("v%0d_err_code", i), {61'd0, eq[0]}, 64'(vecs[i].err));
      if (vecs[i].f1vs >= 0 && fq.size() > 1)
        check($sformatf("v%0d_f1_vsize", i), fq[1].vsize, 64'(vecs[i].f1vs));
    end

    // Downstream backpressure: hold field 35 for five cycles.
    fq.delete();
    eq.delete();
    field_ready = 1'b0;
    fork
      send_msg(good);
      begin
        for (int k = 0; k < 4; k++) begin
          w = 0;
          while (!field_valid && w < 200) begin
            @(negedge clk);
            w++;
          end
          if (w >= 200) begin
            nvec++;
            nmis++;
            $display("FAIL stall_wait: got no field after %0d cycles want field %0d", w, k);
          end
          if (tag == 32'h3335) begin
            snap = consumed;
            for (int c = 0; c < 5; c++) begin
              @(negedge clk);
              check("stall_tag", {32'd0, tag}, 64'h3335);
              check("stall_val", val[63:0], 64'h30);
              check("stall_valid_ready", {62'd0, field_valid, rx_ready}, 64'b10);
              check("stall_consumed", 64'(consumed), 64'(snap));
            end
          end
          @(posedge clk);
          #1 field_ready = 1'b1;
          @(posedge clk);
          #1 field_ready = 1'b0;
        end
      end
    join
    field_ready = 1'b1;
    idle(8);
    check("stall_nfields", 64'(fq.size()), 64'd4);
    check("stall_nerr", 64'(eq.size()), 64'd0);
    if (fq.size() == 4) check("stall_chk_ok", {63'd0, fq[3].chk}, 64'd1);

    // Reset in the middle of field 35's value, then a clean message.
    send_msg("8=FIX.4.2|9=5|35=12");
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    fq.delete();
    eq.delete();
    send_msg(good);
    idle(8);
    check("post_rst_nfields", 64'(fq.size()), 64'd4);
    check("post_rst_nerr", 64'(eq.size()), 64'd0);
    for (int k = 0; k < 4; k++) begin
      if (k < fq.size()) begin
        check($sformatf("f%0d_tag", k), {32'd0, fq[k].tag}, {32'd0, etag[k]});
        check($sformatf("f%0d_tsize", k), {59'd0, fq[k].tsize}, {59'd0, etsz[k]});
        check($sformatf("f%0d_val", k), fq[k].val, eval[k]);
        check($sformatf("f%0d_val_hi", k), {63'd0, fq[k].val_hi_zero}, 64'd1);
        check($sformatf("f%0d_vsize", k), fq[k].vsize, evsz[k]);
        check($sformatf("f%0d_last_chk", k), {62'd0, fq[k].last, fq[k].chk}, (k == 3) ? 64'b11 : 64'b00);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
